// File: rtl/defec_cw_buffer.sv
// Codeword buffer between de-interleaver and FEC decoder: length-checks framed
// soft values, stores good codewords in a two-bank ping-pong RAM, replays them.
module defec_cw_buffer #(
    parameter int unsigned DAT_W  = 5,
    parameter int unsigned CW_LEN = 1920,
    parameter int unsigned ADDR_W = 11
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             isop,
    input  logic             ieop,
    input  logic             ival,
    input  logic [DAT_W-1:0] idat,
    output logic             osop,
    output logic             oeop,
    output logic             oval,
    output logic [DAT_W-1:0] odat,
    input  logic             ordy,
    output logic             olen_err,
    output logic             oovf,
    output logic [15:0]      ocw_cnt,
    output logic [7:0]       odrop_cnt
);
    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_t;
    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wr_st_t;
    typedef enum logic {R_IDLE, R_RUN} rd_st_t;

    localparam logic [ADDR_W:0]   LEN_C  = (ADDR_W+1)'(CW_LEN);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CW_LEN - 1);
    localparam bit                CW_ONE = (CW_LEN == 1);

    logic [DAT_W-1:0] mem [2][CW_LEN];
    bank_st_t         bank_st [2];

    wr_st_t            w_st, w_nxt;
    logic [ADDR_W:0]   wr_cnt, cnt_nxt, beat_cnt;
    logic              wr_ptr;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              fill_start, fill_done, fill_abort;
    logic              len_err_nxt, ovf_nxt;

    rd_st_t            r_st, r_nxt;
    logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
    logic              rd_ptr, rel_ptr;
    logic              issue, issue_sop, issue_eop, rd_take;
    logic              rd_vld_q, rd_sop_q, rd_eop_q;
    logic [DAT_W-1:0]  rd_dat_q;

    logic [DAT_W-1:0]  fq_dat [2];
    logic [1:0]        fq_sop, fq_eop;
    logic              fq_wp, fq_rp;
    logic [1:0]        fq_cnt;
    logic [2:0]        occ;
    logic              pop, room, rel;

    // ---------------- write side ----------------
    always_comb begin
        w_nxt       = w_st;
        cnt_nxt     = wr_cnt;
        we          = 1'b0;
        waddr       = '0;
        fill_start  = 1'b0;
        fill_done   = 1'b0;
        fill_abort  = 1'b0;
        len_err_nxt = 1'b0;
        ovf_nxt     = 1'b0;
        beat_cnt    = wr_cnt + 1'b1;
        case (w_st)
            W_IDLE: begin
                if (ival && isop) begin
                    if (ieop && !CW_ONE) begin
                        len_err_nxt = 1'b1;
                    end else if (bank_st[wr_ptr] == B_EMPTY) begin
                        we         = 1'b1;
                        fill_start = 1'b1;
                        if (ieop) begin
                            fill_done = 1'b1;
                        end else begin
                            w_nxt   = W_FILL;
                            cnt_nxt = (ADDR_W+1)'(1);
                        end
                    end else begin
                        ovf_nxt = 1'b1;
                        if (!ieop) w_nxt = W_DROP;
                    end
                end
            end
            W_FILL: begin
                if (ival) begin
                    we = 1'b1;
                    if (isop) begin
                        // mid-codeword sop: abandon current contents, restart in the same bank
                        len_err_nxt = 1'b1;
                        cnt_nxt     = (ADDR_W+1)'(1);
                        if (ieop) begin
                            fill_abort = 1'b1;
                            w_nxt      = W_IDLE;
                        end
                    end else begin
                        waddr = wr_cnt[ADDR_W-1:0];
                        if (ieop) begin
                            w_nxt = W_IDLE;
                            if (beat_cnt == LEN_C) begin
                                fill_done = 1'b1;
                            end else begin
                                fill_abort  = 1'b1;
                                len_err_nxt = 1'b1;
                            end
                        end else if (beat_cnt == LEN_C) begin
                            fill_abort  = 1'b1;
                            len_err_nxt = 1'b1;
                            w_nxt       = W_DROP;
                        end else begin
                            cnt_nxt = beat_cnt;
                        end
                    end
                end
            end
            W_DROP: begin
                if (ival && ieop) w_nxt = W_IDLE;
            end
            default: w_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            w_st      <= W_IDLE;
            wr_cnt    <= '0;
            wr_ptr    <= 1'b0;
            olen_err  <= 1'b0;
            oovf      <= 1'b0;
            odrop_cnt <= '0;
        end else begin
            w_st     <= w_nxt;
            wr_cnt   <= cnt_nxt;
            olen_err <= len_err_nxt;
            oovf     <= ovf_nxt;
            if (fill_done) wr_ptr <= ~wr_ptr;
            if ((len_err_nxt || ovf_nxt) && odrop_cnt != 8'hFF)
                odrop_cnt <= odrop_cnt + 8'd1;
        end
    end

    // Writer and reader never touch the same bank in one cycle, so updates do not collide.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            bank_st[0] <= B_EMPTY;
            bank_st[1] <= B_EMPTY;
        end else begin
            if (fill_start) bank_st[wr_ptr] <= B_FILLING;
            if (fill_done)  bank_st[wr_ptr] <= B_FULL;
            if (fill_abort) bank_st[wr_ptr] <= B_EMPTY;
            if (rd_take)    bank_st[rd_ptr] <= B_READING;
            if (rel)        bank_st[rel_ptr] <= B_EMPTY;
        end
    end

    always_ff @(posedge iclk) begin
        if (we)    mem[wr_ptr][waddr] <= idat;
        if (issue) rd_dat_q <= mem[rd_ptr][rd_addr];
    end

    // ---------------- read side ----------------
    assign pop  = oval && ordy;
    assign rel  = pop && oeop;
    assign occ  = {1'b0, fq_cnt} + {2'b0, rd_vld_q} - {2'b0, pop};
    assign room = (occ <= 3'd1);

    // R_IDLE issues address 0 itself so consecutive banks stream without a gap.
    always_comb begin
        r_nxt       = r_st;
        rd_addr_nxt = rd_addr;
        issue       = 1'b0;
        issue_sop   = 1'b0;
        issue_eop   = 1'b0;
        rd_take     = 1'b0;
        case (r_st)
            R_IDLE: begin
                if (bank_st[rd_ptr] == B_FULL && room) begin
                    rd_take   = 1'b1;
                    issue     = 1'b1;
                    issue_sop = 1'b1;
                    if (CW_ONE) begin
                        issue_eop = 1'b1;
                    end else begin
                        r_nxt       = R_RUN;
                        rd_addr_nxt = ADDR_W'(1);
                    end
                end
            end
            R_RUN: begin
                if (room) begin
                    issue = 1'b1;
                    if (rd_addr == LAST_A) begin
                        issue_eop   = 1'b1;
                        r_nxt       = R_IDLE;
                        rd_addr_nxt = '0;
                    end else begin
                        rd_addr_nxt = rd_addr + 1'b1;
                    end
                end
            end
            default: r_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_st     <= R_IDLE;
            rd_addr  <= '0;
            rd_ptr   <= 1'b0;
            rel_ptr  <= 1'b0;
            ocw_cnt  <= '0;
            rd_vld_q <= 1'b0;
            rd_sop_q <= 1'b0;
            rd_eop_q <= 1'b0;
        end else begin
            r_st     <= r_nxt;
            rd_addr  <= rd_addr_nxt;
            rd_vld_q <= issue;
            rd_sop_q <= issue_sop;
            rd_eop_q <= issue_eop;
            if (issue_eop) rd_ptr <= ~rd_ptr;
            if (rel) begin
                rel_ptr <= ~rel_ptr;
                ocw_cnt <= ocw_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            fq_dat[0] <= '0;
            fq_dat[1] <= '0;
            fq_sop    <= '0;
            fq_eop    <= '0;
            fq_wp     <= 1'b0;
            fq_rp     <= 1'b0;
            fq_cnt    <= '0;
        end else begin
            if (rd_vld_q) begin
                fq_dat[fq_wp] <= rd_dat_q;
                fq_sop[fq_wp] <= rd_sop_q;
                fq_eop[fq_wp] <= rd_eop_q;
                fq_wp         <= ~fq_wp;
            end
            if (pop) fq_rp <= ~fq_rp;
            fq_cnt <= fq_cnt + {1'b0, rd_vld_q} - {1'b0, pop};
        end
    end

    assign oval = (fq_cnt != 2'd0);
    assign odat = oval ? fq_dat[fq_rp] : '0;
    assign osop = oval & fq_sop[fq_rp];
    assign oeop = oval & fq_eop[fq_rp];

endmodule

// File: tb/tb_defec_cw_buffer.sv
// Scoreboard bench for defec_cw_buffer: stimulus queues expected beats,
// a monitor pops and compares on every output transfer.
module tb_defec_cw_buffer;
    localparam int unsigned DAT_W  = 5;
    localparam int unsigned CW_LEN = 1920;
    localparam int unsigned ADDR_W = 11;

    typedef struct packed {
        logic             sop;
        logic             eop;
        logic [DAT_W-1:0] dat;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             isop = 1'b0, ieop = 1'b0, ival = 1'b0;
    logic [DAT_W-1:0] idat = '0;
    logic             osop, oeop, oval, ordy;
    logic [DAT_W-1:0] odat;
    logic             olen_err, oovf;
    logic [15:0]      ocw_cnt;
    logic [7:0]       odrop_cnt;

    bit               rnd_mode = 1'b0;
    bit               ordy_force = 1'b0;

    beat_t            exp_q[$];
    int unsigned      n_checks = 0, n_pass = 0;
    int unsigned      smp = 0, eop_smp = 0, run_start = 0;
    int unsigned      len_pulses = 0, ovf_pulses = 0, n_xfer = 0;
    bit               lat_arm = 1'b0, run_arm = 1'b0;
    bit               prev_stall = 1'b0, prev_oval = 1'b0;
    logic [7:0]       prev_vec = '0;

    defec_cw_buffer #(.DAT_W(DAT_W), .CW_LEN(CW_LEN), .ADDR_W(ADDR_W)) dut (
        .iclk(clk), .irst(rst),
        .isop(isop), .ieop(ieop), .ival(ival), .idat(idat),
        .osop(osop), .oeop(oeop), .oval(oval), .odat(odat), .ordy(ordy),
        .olen_err(olen_err), .oovf(oovf), .ocw_cnt(ocw_cnt), .odrop_cnt(odrop_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) ordy = rnd_mode ? ($urandom_range(0, 99) >= 30) : ordy_force;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    function automatic logic [DAT_W-1:0] pat(input int unsigned seed, input int unsigned i);
        return DAT_W'((i * 7 + seed * 11 + i / 13) % 32);
    endfunction

    // Monitor: samples 1 time unit after the falling edge, i.e. the values seen at the next rising edge.
    always begin
        beat_t e;
        @(negedge clk);
        #1;
        smp++;
        if (!rst) begin
            prev_stall = 1'b0;
            prev_oval  = 1'b0;
        end else begin
            if (ival && ieop) eop_smp = smp;
            if (olen_err) len_pulses++;
            if (oovf) ovf_pulses++;
            if (prev_stall) chk("stall_hold", {oval, osop, oeop, odat}, prev_vec);
            if (lat_arm && oval && !prev_oval) begin
                chk("latency", smp - eop_smp, 3);
                run_start = smp;
                run_arm   = 1'b1;
                lat_arm   = 1'b0;
            end
            if (oval && ordy) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_beat: got sop=%0b eop=%0b dat=%0d, expected no beat", osop, oeop, odat);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", {osop, oeop, odat}, e);
                    if (run_arm && oeop) begin
                        chk("run_len", smp - run_start, CW_LEN - 1);
                        run_arm = 1'b0;
                    end
                end
            end
            prev_stall = oval && !ordy;
            prev_vec   = {oval, osop, oeop, odat};
            prev_oval  = oval;
        end
    end

    task automatic send_cw(input int unsigned n, input int unsigned seed, input bit keep, input bit with_eop);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ival = 1'b1;
            isop = (i == 0);
            ieop = with_eop && (i == n - 1);
            idat = pat(seed, i);
            if (keep) exp_q.push_back(beat_t'({isop, ieop, idat}));
        end
    endtask

    task automatic idle_in(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ival = 1'b0;
            isop = 1'b0;
            ieop = 1'b0;
        end
    endtask

    task automatic drain(input string name, input int unsigned lim);
        int unsigned n = 0;
        while ((exp_q.size() != 0 || oval) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned bl, bo, bx, n;

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_oval", oval, 0);
        chk("rst_osop", osop, 0);
        chk("rst_oeop", oeop, 0);
        chk("rst_odat", odat, 0);
        chk("rst_olen_err", olen_err, 0);
        chk("rst_oovf", oovf, 0);
        chk("rst_ocw_cnt", ocw_cnt, 0);
        chk("rst_odrop_cnt", odrop_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        ordy_force = 1'b1;
        idle_in(4);

        // single codeword, full throughput, latency and run length
        lat_arm = 1'b1;
        send_cw(CW_LEN, 1, 1'b1, 1'b1);
        idle_in(1);
        drain("t1_drain", 3000);
        chk("t1_ocw_cnt", ocw_cnt, 1);
        chk("t1_odrop_cnt", odrop_cnt, 0);
        chk("t1_latency_seen", lat_arm, 0);

        // three back-to-back with output stalled: third overflows
        ordy_force = 1'b0;
        idle_in(3);
        bl = len_pulses; bo = ovf_pulses;
        send_cw(CW_LEN, 2, 1'b1, 1'b1);
        send_cw(CW_LEN, 3, 1'b1, 1'b1);
        send_cw(CW_LEN, 4, 1'b0, 1'b1);
        idle_in(10);
        chk("t2_ovf_pulses", ovf_pulses - bo, 1);
        chk("t2_len_pulses", len_pulses - bl, 0);
        chk("t2_odrop_cnt", odrop_cnt, 1);
        chk("t2_stall_oval", oval, 1);
        chk("t2_ocw_stalled", ocw_cnt, 1);
        ordy_force = 1'b1;
        drain("t2_drain", 6000);
        chk("t2_ocw_cnt", ocw_cnt, 3);

        // short codeword then good codeword
        bl = len_pulses; bo = ovf_pulses;
        send_cw(1000, 5, 1'b0, 1'b1);
        send_cw(CW_LEN, 6, 1'b1, 1'b1);
        idle_in(1);
        drain("t3_drain", 3000);
        chk("t3_len_pulses", len_pulses - bl, 1);
        chk("t3_ovf_pulses", ovf_pulses - bo, 0);
        chk("t3_odrop_cnt", odrop_cnt, 2);
        chk("t3_ocw_cnt", ocw_cnt, 4);

        // sop at beat 500 restarts the codeword
        bl = len_pulses;
        send_cw(500, 7, 1'b0, 1'b0);
        send_cw(CW_LEN, 8, 1'b1, 1'b1);
        idle_in(1);
        drain("t4_drain", 3000);
        chk("t4_len_pulses", len_pulses - bl, 1);
        chk("t4_odrop_cnt", odrop_cnt, 3);
        chk("t4_ocw_cnt", ocw_cnt, 5);

        // random back-pressure over four codewords
        rnd_mode = 1'b1;
        bl = len_pulses; bo = ovf_pulses;
        for (int unsigned k = 0; k < 4; k++) begin
            n = 0;
            while (exp_q.size() > CW_LEN && n < 8000) begin
                @(negedge clk);
                n++;
            end
            chk("t5_bank_wait", (exp_q.size() > CW_LEN) ? 1 : 0, 0);
            send_cw(CW_LEN, 9 + k, 1'b1, 1'b1);
            idle_in($urandom_range(1, 20));
        end
        drain("t5_drain", 10000);
        rnd_mode = 1'b0;
        chk("t5_ocw_cnt", ocw_cnt, 9);
        chk("t5_drops", (len_pulses - bl) + (ovf_pulses - bo), 0);
        chk("t5_odrop_cnt", odrop_cnt, 3);

        // reset in the middle of an output codeword
        idle_in(2);
        bx = n_xfer;
        send_cw(CW_LEN, 20, 1'b1, 1'b1);
        idle_in(1);
        n = 0;
        while (n_xfer - bx < 960 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_960", n_xfer - bx, 960);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_oval", oval, 0);
        idle_in(3);
        #1;
        chk("t6_rst_ocw_cnt", ocw_cnt, 0);
        chk("t6_rst_odrop_cnt", odrop_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        bx = n_xfer;
        // trailing beats without sop must not start a codeword
        for (int unsigned i = 0; i < 100; i++) begin
            @(negedge clk);
            ival = 1'b1;
            isop = 1'b0;
            ieop = (i == 99);
            idat = pat(21, i);
        end
        idle_in(30);
        chk("t6_quiet", n_xfer - bx, 0);
        chk("t6_quiet_oval", oval, 0);
        send_cw(CW_LEN, 22, 1'b1, 1'b1);
        idle_in(1);
        drain("t6_drain", 3000);
        chk("t6_ocw_cnt", ocw_cnt, 1);
        chk("t6_odrop_cnt", odrop_cnt, 0);

        idle_in(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
